// File: rtl/morph_pkg.sv
// rtl/morph_pkg.sv - shared types and constants for the morphology frame controller
package morph_pkg;

   typedef enum logic [2:0] {
      BYPASS = 3'd0,
      ERODE  = 3'd1,
      DILATE = 3'd2,
      OPEN   = 3'd3,
      CLOSE  = 3'd4
   } morph_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_DONE   = 2'd3
   } ctrl_state_e;

   localparam int CNT_W  = 19;
   localparam int HCNT_W = 10;

   localparam logic [CNT_W-1:0]  FG_MAX   = '1;
   localparam logic [HCNT_W-1:0] HCNT_MAX = '1;

   localparam int ERR_HCNT    = 0;
   localparam int ERR_VCNT    = 1;
   localparam int ERR_OVERLAP = 2;
   localparam int ERR_TIMEOUT = 3;

   // Codes 5-7 have no morphology stage behind them, so they fall back to bypass.
   function automatic morph_mode_e decode_mode(input logic [2:0] m);
      case (m)
         3'd1:    return ERODE;
         3'd2:    return DILATE;
         3'd3:    return OPEN;
         3'd4:    return CLOSE;
         default: return BYPASS;
      endcase
   endfunction

endpackage

// File: rtl/morph_line_meter.sv
// rtl/morph_line_meter.sv - per-line pixel counter with line-length check and saturating line count
module morph_line_meter
   import morph_pkg::*;
#(
   parameter logic [HCNT_W-1:0] IMG_HDISP = 10'd640
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              enable,
   input  logic              href_fall,
   input  logic              pix_valid,
   output logic [HCNT_W-1:0] vcnt,
   output logic              hcnt_err
);

   logic [HCNT_W-1:0] hcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt     <= '0;
         vcnt     <= '0;
         hcnt_err <= 1'b0;
      end else if (clear) begin
         hcnt     <= '0;
         vcnt     <= '0;
         hcnt_err <= 1'b0;
      end else if (enable) begin
         if (href_fall) begin
            if (hcnt != IMG_HDISP)
               hcnt_err <= 1'b1;
            // A pixel landing on the same cycle as the detected fall belongs to the next line.
            hcnt <= {{(HCNT_W-1){1'b0}}, pix_valid};
            if (vcnt != HCNT_MAX)
               vcnt <= vcnt + 1'b1;
         end else if (pix_valid && hcnt != HCNT_MAX) begin
            hcnt <= hcnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/morph_frame_ctrl.sv
// rtl/morph_frame_ctrl.sv - frame sequencer, config shadowing and motion result publishing
module morph_frame_ctrl
   import morph_pkg::*;
#(
   parameter logic [9:0]  IMG_HDISP = 10'd640,
   parameter logic [9:0]  IMG_VDISP = 10'd480,
   parameter logic [15:0] DRAIN_MAX = 16'd4096
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   input  logic [2:0]       cfg_mode,
   input  logic [CNT_W-1:0] cfg_thresh,
   input  logic             per_frame_vsync,
   input  logic             per_frame_href,
   input  logic             post_vsync,
   input  logic             post_href,
   input  logic             post_clken,
   input  logic             post_img_Bit,
   output logic [2:0]       mode_sel,
   output logic             busy,
   output logic             cfg_pending,
   output logic             frame_done,
   output logic [CNT_W-1:0] motion_cnt,
   output logic             motion_flag,
   output logic [3:0]       err_flags
);

   localparam logic [15:0] DRAIN_LAST = DRAIN_MAX - 16'd1;

   ctrl_state_e       state;
   logic              per_vs_q, per_vs_q2;
   logic              per_hr_q, per_hr_q2;
   logic              post_vs_q;
   logic              post_hr_q, post_hr_q2;
   logic [2:0]        pend_mode;
   logic [CNT_W-1:0]  pend_thresh;
   logic [CNT_W-1:0]  shadow_thresh;
   logic [15:0]       drain_timer;
   logic [CNT_W-1:0]  fg;
   logic              timeout_err;
   logic              overlap_err;
   logic [HCNT_W-1:0] vcnt;
   logic              hcnt_err;

   logic per_rise, per_fall, per_hr_rise, post_hr_fall;
   logic measuring, frame_start, pix_valid;

   assign per_rise     = per_vs_q & ~per_vs_q2;
   assign per_fall     = ~per_vs_q & per_vs_q2;
   assign per_hr_rise  = per_hr_q & ~per_hr_q2;
   assign post_hr_fall = ~post_hr_q & post_hr_q2;
   assign measuring    = (state == ST_ACTIVE) || (state == ST_DRAIN);
   assign frame_start  = (state == ST_IDLE) && per_rise;
   assign pix_valid    = post_clken & post_href;

   // Input vsync history resets high so a frame already in flight at reset release never looks like a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_vs_q   <= 1'b1;
         per_vs_q2  <= 1'b1;
         per_hr_q   <= 1'b0;
         per_hr_q2  <= 1'b0;
         post_vs_q  <= 1'b0;
         post_hr_q  <= 1'b0;
         post_hr_q2 <= 1'b0;
      end else begin
         per_vs_q   <= per_frame_vsync;
         per_vs_q2  <= per_vs_q;
         per_hr_q   <= per_frame_href;
         per_hr_q2  <= per_hr_q;
         post_vs_q  <= post_vsync;
         post_hr_q  <= post_href;
         post_hr_q2 <= post_hr_q;
      end
   end

   morph_line_meter #(.IMG_HDISP(IMG_HDISP)) u_line_meter (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (frame_start),
      .enable    (measuring),
      .href_fall (post_hr_fall),
      .pix_valid (pix_valid),
      .vcnt      (vcnt),
      .hcnt_err  (hcnt_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         mode_sel      <= 3'd0;
         busy          <= 1'b0;
         cfg_pending   <= 1'b0;
         frame_done    <= 1'b0;
         motion_cnt    <= '0;
         motion_flag   <= 1'b0;
         err_flags     <= 4'd0;
         pend_mode     <= 3'd0;
         pend_thresh   <= '0;
         shadow_thresh <= '0;
         drain_timer   <= 16'd0;
         fg            <= '0;
         timeout_err   <= 1'b0;
         overlap_err   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (cfg_valid) begin
            pend_mode   <= cfg_mode;
            pend_thresh <= cfg_thresh;
            cfg_pending <= 1'b1;
         end
         if (measuring && pix_valid && post_img_Bit && fg != FG_MAX)
            fg <= fg + 1'b1;

         case (state)
            ST_IDLE: begin
               if (per_rise) begin
                  state <= ST_ACTIVE;
                  busy  <= 1'b1;
                  // A config arriving on the start cycle is newer than anything pending.
                  if (cfg_valid) begin
                     mode_sel      <= decode_mode(cfg_mode);
                     shadow_thresh <= cfg_thresh;
                  end else if (cfg_pending) begin
                     mode_sel      <= decode_mode(pend_mode);
                     shadow_thresh <= pend_thresh;
                  end
                  cfg_pending <= 1'b0;
                  fg          <= '0;
                  timeout_err <= 1'b0;
                  overlap_err <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (per_fall) begin
                  state       <= ST_DRAIN;
                  drain_timer <= 16'd0;
               end
            end
            ST_DRAIN: begin
               // New input frame or line while the previous frame is still draining.
               if (per_rise || per_hr_rise)
                  overlap_err <= 1'b1;
               if (!post_vs_q) begin
                  state <= ST_DONE;
               end else if (drain_timer == DRAIN_LAST) begin
                  state       <= ST_DONE;
                  timeout_err <= 1'b1;
               end else begin
                  drain_timer <= drain_timer + 16'd1;
               end
            end
            ST_DONE: begin
               state                  <= ST_IDLE;
               busy                   <= 1'b0;
               frame_done             <= 1'b1;
               motion_cnt             <= fg;
               motion_flag            <= (fg >= shadow_thresh);
               err_flags[ERR_HCNT]    <= hcnt_err;
               err_flags[ERR_VCNT]    <= (vcnt != IMG_VDISP);
               err_flags[ERR_OVERLAP] <= overlap_err;
               err_flags[ERR_TIMEOUT] <= timeout_err;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_morph_frame_ctrl.sv
// tb/tb_morph_frame_ctrl.sv - directed scoreboard bench for morph_frame_ctrl
module tb_morph_frame_ctrl;

   localparam logic [9:0]  HD = 10'd16;
   localparam logic [9:0]  VD = 10'd12;
   localparam logic [15:0] DM = 16'd64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_valid = 1'b0;
   logic [2:0]  cfg_mode = 3'd0;
   logic [18:0] cfg_thresh = 19'd0;
   logic        per_frame_vsync = 1'b0;
   logic        per_frame_href = 1'b0;
   logic        post_vsync = 1'b0;
   logic        post_href = 1'b0;
   logic        post_clken = 1'b0;
   logic        post_img_Bit = 1'b0;
   logic [2:0]  mode_sel;
   logic        busy;
   logic        cfg_pending;
   logic        frame_done;
   logic [18:0] motion_cnt;
   logic        motion_flag;
   logic [3:0]  err_flags;

   morph_frame_ctrl #(.IMG_HDISP(HD), .IMG_VDISP(VD), .DRAIN_MAX(DM)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .cfg_valid       (cfg_valid),
      .cfg_mode        (cfg_mode),
      .cfg_thresh      (cfg_thresh),
      .per_frame_vsync (per_frame_vsync),
      .per_frame_href  (per_frame_href),
      .post_vsync      (post_vsync),
      .post_href       (post_href),
      .post_clken      (post_clken),
      .post_img_Bit    (post_img_Bit),
      .mode_sel        (mode_sel),
      .busy            (busy),
      .cfg_pending     (cfg_pending),
      .frame_done      (frame_done),
      .motion_cnt      (motion_cnt),
      .motion_flag     (motion_flag),
      .err_flags       (err_flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [18:0] cnt;
      logic        flag;
      logic [3:0]  err;
      logic [2:0]  mode;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   done_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input int cnt, input logic flag, input logic [3:0] err, input logic [2:0] mode);
      exp_t e;
      e.cnt  = 19'(cnt);
      e.flag = flag;
      e.err  = err;
      e.mode = mode;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (frame_done) begin
         done_cnt++;
         check("done_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("motion_cnt", 32'(motion_cnt), 32'(e.cnt));
            check("motion_flag", 32'(motion_flag), 32'(e.flag));
            check("err_flags", 32'(err_flags), 32'(e.err));
            check("mode_sel_done", 32'(mode_sel), 32'(e.mode));
         end
      end
   end

   task automatic cfg_pulse(input logic [2:0] m, input logic [18:0] t);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_mode = m; cfg_thresh = t;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   // The vsync rise is acted on two edges after it is driven; cfg_now lands exactly on that edge.
   task automatic start_frame(input logic cfg_now, input logic [2:0] m, input logic [18:0] t);
      @(negedge clk);
      per_frame_vsync = 1'b1; post_vsync = 1'b1;
      @(negedge clk);
      if (cfg_now) begin
         cfg_valid = 1'b1; cfg_mode = m; cfg_thresh = t;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_lines(input int lines, input int short_ln, input int nfg);
      int left = nfg;
      for (int l = 0; l < lines; l++) begin
         per_frame_href = 1'b1; post_href = 1'b1;
         for (int p = 0; p < int'(HD); p++) begin
            post_clken   = !(l == short_ln && p == int'(HD) - 1);
            post_img_Bit = post_clken && (left > 0);
            if (post_img_Bit) left--;
            @(negedge clk);
         end
         per_frame_href = 1'b0; post_href = 1'b0; post_clken = 1'b0; post_img_Bit = 1'b0;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic settle(input string tag);
      repeat (12) @(negedge clk);
      check(tag, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_mode_sel", 32'(mode_sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cfg_pending", 32'(cfg_pending), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_motion_cnt", 32'(motion_cnt), 32'd0);
      check("rst_motion_flag", 32'(motion_flag), 32'd0);
      check("rst_err_flags", 32'(err_flags), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Frame 1: open mode, clean geometry, 25 fg pixels over threshold 20; config change mid-frame is deferred.
      cfg_pulse(3'd3, 19'd20);
      check("f1_pending_set", 32'(cfg_pending), 32'd1);
      check("f1_mode_before", 32'(mode_sel), 32'd0);
      start_frame(1'b0, 3'd0, 19'd0);
      check("f1_mode_start", 32'(mode_sel), 32'd3);
      check("f1_busy", 32'(busy), 32'd1);
      check("f1_pending_clr", 32'(cfg_pending), 32'd0);
      cfg_pulse(3'd2, 19'd30);
      check("f1_mode_hold", 32'(mode_sel), 32'd3);
      check("f1_pending_mid", 32'(cfg_pending), 32'd1);
      send_lines(int'(VD), -1, 25);
      push_exp(25, 1'b1, 4'b0000, 3'd3);
      per_frame_vsync = 1'b0; post_vsync = 1'b0;
      settle("f1_done_seen");
      check("f1_mode_after", 32'(mode_sel), 32'd3);
      check("f1_pending_after", 32'(cfg_pending), 32'd1);
      check("f1_busy_after", 32'(busy), 32'd0);

      // Frame 2: deferred dilate config takes effect; one short line.
      start_frame(1'b0, 3'd0, 19'd0);
      check("f2_mode_start", 32'(mode_sel), 32'd2);
      check("f2_pending_clr", 32'(cfg_pending), 32'd0);
      send_lines(int'(VD), 3, 10);
      push_exp(10, 1'b0, 4'b0001, 3'd2);
      per_frame_vsync = 1'b0; post_vsync = 1'b0;
      settle("f2_done_seen");

      // Frame 3: config on the start cycle beats the pending one; mode 6 maps to bypass; one line short; fg equals threshold.
      cfg_pulse(3'd1, 19'd5);
      start_frame(1'b1, 3'd6, 19'd30);
      check("f3_mode_start", 32'(mode_sel), 32'd0);
      check("f3_pending_clr", 32'(cfg_pending), 32'd0);
      send_lines(int'(VD) - 1, -1, 30);
      push_exp(30, 1'b1, 4'b0010, 3'd0);
      per_frame_vsync = 1'b0; post_vsync = 1'b0;
      settle("f3_done_seen");

      // Frame 4: post_vsync stuck high; done arrives after 2 sync edges, DM cycles of DRAIN and one DONE cycle.
      start_frame(1'b0, 3'd0, 19'd0);
      send_lines(int'(VD), -1, 29);
      push_exp(29, 1'b0, 4'b1000, 3'd0);
      per_frame_vsync = 1'b0;
      n = 0;
      while (n < int'(DM) + 20) begin
         @(negedge clk);
         n++;
         if (frame_done) break;
      end
      check("f4_timeout_latency", 32'(n), 32'(int'(DM) + 3));
      post_vsync = 1'b0;
      settle("f4_done_seen");

      // Frame 5: next input frame starts while draining; it must be skipped.
      start_frame(1'b0, 3'd0, 19'd0);
      send_lines(int'(VD), -1, 5);
      push_exp(5, 1'b0, 4'b0100, 3'd0);
      per_frame_vsync = 1'b0;
      repeat (6) @(negedge clk);
      per_frame_vsync = 1'b1;
      repeat (6) @(negedge clk);
      post_vsync = 1'b0;
      settle("f5_done_seen");
      repeat (10) @(negedge clk);
      per_frame_vsync = 1'b0;
      settle("f5_skip_quiet");

      // Frame 6: sequencing resumes normally after the skipped frame.
      cfg_pulse(3'd4, 19'd7);
      start_frame(1'b0, 3'd0, 19'd0);
      check("f6_mode_start", 32'(mode_sel), 32'd4);
      send_lines(int'(VD), -1, 7);
      push_exp(7, 1'b1, 4'b0000, 3'd4);
      per_frame_vsync = 1'b0; post_vsync = 1'b0;
      settle("f6_done_seen");

      // Reset in the middle of a frame clears every output without a clock edge.
      start_frame(1'b1, 3'd1, 19'd3);
      cfg_pulse(3'd2, 19'd9);
      send_lines(3, -1, 0);
      check("pre_rst_mode", 32'(mode_sel), 32'd1);
      check("pre_rst_pending", 32'(cfg_pending), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_mode_sel", 32'(mode_sel), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_cfg_pending", 32'(cfg_pending), 32'd0);
      check("arst_frame_done", 32'(frame_done), 32'd0);
      check("arst_motion_cnt", 32'(motion_cnt), 32'd0);
      check("arst_motion_flag", 32'(motion_flag), 32'd0);
      check("arst_err_flags", 32'(err_flags), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      send_lines(3, -1, 0);
      check("post_rst_idle", 32'(busy), 32'd0);
      per_frame_vsync = 1'b0; post_vsync = 1'b0;
      settle("post_rst_quiet");

      // Frame 7: full frame after reset, cleared shadow gives bypass and threshold 0.
      start_frame(1'b0, 3'd0, 19'd0);
      check("f7_busy", 32'(busy), 32'd1);
      send_lines(int'(VD), -1, 0);
      push_exp(0, 1'b1, 4'b0000, 3'd0);
      per_frame_vsync = 1'b0; post_vsync = 1'b0;
      settle("f7_done_seen");

      check("done_count", 32'(done_cnt), 32'd7);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
